// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalize/round/pack block.
// Holds the FSM state encoding, field widths, the layout of the raw ALU
// mantissa and a helper that packs sign/exponent/fraction into an
// IEEE-754 single-precision word.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 28;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Raw mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2:0] G/R/S
    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int FRAC_LSB   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] fp_pack(input logic             sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_round.sv
// Round-to-nearest-even helper (purely combinational).
// Ports:
//   sig_in      : hidden bit + fraction (24 bits), LSB is the fraction LSB
//   guard/round_bit/sticky : bits below the fraction LSB
//   round_inc   : 1 when RNE says to add one ULP
//   round_carry : the increment overflowed past the hidden bit
//   sig_out     : rounded significand (all zero when round_carry is set,
//                 which is exactly the fraction of the renormalized value)
module fp_round
    import fp_pkg::*;
(
    input  logic [FRAC_W:0] sig_in,
    input  logic            guard,
    input  logic            round_bit,
    input  logic            sticky,
    output logic            round_inc,
    output logic            round_carry,
    output logic [FRAC_W:0] sig_out
);

    // Above half rounds up; an exact half rounds up only to reach an even LSB.
    assign round_inc = guard & (round_bit | sticky | sig_in[0]);
    assign {round_carry, sig_out} = {1'b0, sig_in} + {{(FRAC_W+1){1'b0}}, round_inc};

endmodule

// File: rtl/fp_normalize.sv
// Normalize, round and pack a raw floating-point add/sub result.
// One shift per cycle in SHIFT, then optional RNE rounding in ROUND, then
// the packed result is held in DONE until the consumer takes it.
// Build option: FP_NORM_ROUND_EN compiles in the ROUND state and RNE
// rounding; without it G/R/S are truncated and SHIFT goes straight to DONE.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake (ready only in IDLE)
//   in_sign/exp/mant  : raw result; mant[27:0] used, [31:28] ignored
//   out_valid/ready   : output handshake (valid only in DONE)
//   out_result        : IEEE-754 single-precision result
//   out_zero/ovf/unf  : at most one set: zero, overflow (inf), underflow (flush)
module fp_normalize
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [31:0]      in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_unf
);

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic [31:0]         result_q, result_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic unused_mant_hi;
    assign unused_mant_hi = ^in_mant[31:MANT_W];

`ifdef FP_NORM_ROUND_EN
    logic               round_inc, round_carry;
    logic [FRAC_W:0]    sig_rnd;
    logic [EXP_W-1:0]   exp_rnd;

    fp_round u_round (
        .sig_in      (mant_q[HIDDEN_BIT:FRAC_LSB]),
        .guard       (mant_q[2]),
        .round_bit   (mant_q[1]),
        .sticky      (mant_q[0]),
        .round_inc   (round_inc),
        .round_carry (round_carry),
        .sig_out     (sig_rnd)
    );

    assign exp_rnd = exp_q + {{(EXP_W-1){1'b0}}, round_carry};
`endif

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mant_d  = in_mant[MANT_W-1:0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (mant_q == '0) begin
                    result_d = '0;
                    {zero_d, ovf_d, unf_d} = 3'b100;
                    state_d  = DONE;
                end else if (exp_q == EXP_MAX) begin
                    result_d = fp_pack(sign_q, EXP_MAX, '0);
                    {zero_d, ovf_d, unf_d} = 3'b010;
                    state_d  = DONE;
                end else if (mant_q[CARRY_BIT]) begin
                    // The bit shifted out lands in sticky so rounding still sees it.
                    mant_d = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 1'b1;
                end else if (!mant_q[HIDDEN_BIT] && exp_q <= 8'd1) begin
                    result_d = fp_pack(sign_q, '0, '0);
                    {zero_d, ovf_d, unf_d} = 3'b001;
                    state_d  = DONE;
                end else if (!mant_q[HIDDEN_BIT]) begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - 1'b1;
                end else begin
`ifdef FP_NORM_ROUND_EN
                    state_d = ROUND;
`else
                    result_d = fp_pack(sign_q, exp_q, mant_q[HIDDEN_BIT-1:FRAC_LSB]);
                    {zero_d, ovf_d, unf_d} = 3'b000;
                    state_d  = DONE;
`endif
                end
            end
`ifdef FP_NORM_ROUND_EN
            ROUND: begin
                // On a rounding carry sig_rnd is all zero, which is also the
                // fraction after the renormalizing right shift.
                if (exp_rnd == EXP_MAX) begin
                    result_d = fp_pack(sign_q, EXP_MAX, '0);
                    {zero_d, ovf_d, unf_d} = 3'b010;
                end else begin
                    result_d = fp_pack(sign_q, exp_rnd,
                                       round_inc ? sig_rnd[FRAC_W-1:0]
                                                 : mant_q[HIDDEN_BIT-1:FRAC_LSB]);
                    {zero_d, ovf_d, unf_d} = 3'b000;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;

endmodule

// File: tb/tb_fp_normalize.sv
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [31:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero, out_ovf, out_unf;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero, ovf, unf;
        int          lat;
    } model_t;

    fp_normalize dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf)
    );

    always #5 clk = ~clk;

`ifdef FP_NORM_ROUND_EN
    localparam int RND_CYC = 1;
`else
    localparam int RND_CYC = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: value = m * 2^(e - bias) with the binary point after bit 26.
    // Latency counts the accept edge as cycle 1, then one cycle per shift,
    // one for the final decision, plus one for rounding of a normal value.
    function automatic model_t ref_model(input logic s, input logic [7:0] e_in, input logic [31:0] m_in);
        model_t r;
        int e, p, k, steps;
        logic [31:0] m;
        logic [24:0] sig;
        logic [2:0]  grs;
        r.res = 0; r.zero = 0; r.ovf = 0; r.unf = 0; r.lat = 2;
        e = int'(e_in);
        m = m_in & 32'h0FFF_FFFF;
        if (m == 0) begin r.zero = 1; return r; end
        if (e == 255) begin r.ovf = 1; r.res = {s, 8'hFF, 23'h0}; return r; end
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        steps = 0;
        if (p == 27) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
            steps = 1;
            if (e == 255) begin r.ovf = 1; r.res = {s, 8'hFF, 23'h0}; r.lat = 3; return r; end
        end else if (p < 26) begin
            k = 26 - p;
            if (e - k < 1) begin
                r.unf = 1; r.res = {s, 31'h0};
                r.lat = 2 + ((e > 1) ? e - 1 : 0);
                return r;
            end
            m = m << k;
            e = e - k;
            steps = k;
        end
        sig = {1'b0, m[26:3]};
        grs = m[2:0];
        if (RND_CYC == 1) begin
            if (grs > 3'd4 || (grs == 3'd4 && sig[0])) sig = sig + 1;
            if (sig[24]) begin sig = sig >> 1; e = e + 1; end
        end
        r.lat = 2 + steps + RND_CYC;
        if (e == 255) begin r.ovf = 1; r.res = {s, 8'hFF, 23'h0}; return r; end
        r.res = {s, e[7:0], sig[22:0]};
        return r;
    endfunction

    task automatic run_op(input logic s, input logic [7:0] e, input logic [31:0] m,
                          input int hold, input string tag);
        model_t r;
        int     lat;
        r = ref_model(s, e, m);
        @(negedge clk);
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; out_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_mant  = $urandom;
        in_exp   = 8'($urandom);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, r.lat);
        check({tag, " result"}, out_result, r.res);
        check({tag, " flags"}, {29'd0, out_zero, out_ovf, out_unf}, {29'd0, r.zero, r.ovf, r.unf});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, {out_valid, in_ready, out_result[29:0]}, {1'b1, 1'b0, r.res[29:0]});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " release"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outputs", {out_valid, out_zero, out_ovf, out_unf, out_result[27:0]}, 32'd0);
        check("reset result", out_result, 32'd0);
        rst = 1'b0;
        check("ready after reset", {31'd0, in_ready}, 32'd1);

        run_op(1'b0, 8'd127, 32'h0800_0000, 0, "carry");
        run_op(1'b0, 8'd127, 32'h0000_0008, 0, "cancel");
        run_op(1'b1, 8'd100, 32'h0000_0000, 0, "zero");
        run_op(1'b0, 8'd254, 32'h0800_0000, 0, "ovf");
        run_op(1'b0, 8'd127, 32'h07FF_FFFC, 0, "round");
        run_op(1'b1, 8'd1,   32'h0200_0000, 0, "unf");
        run_op(1'b1, 8'd200, 32'h0400_0000, 10, "backpressure");
        run_op(1'b0, 8'd255, 32'h0400_0000, 0, "exp255");
        run_op(1'b0, 8'd127, 32'hF400_0000, 0, "upper ignored");

        // Reset in the middle of a long shift sequence
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 32'h0000_0008;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset outputs", {out_valid, out_zero, out_ovf, out_unf, out_result[27:0]}, 32'd0);
        rst = 1'b0;
        check("mid reset ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no output after reset", {31'd0, seen}, 32'd0);
        run_op(1'b0, 8'd127, 32'h0000_0008, 0, "post reset");

        // Random operands spread over all leading-one positions
        for (int n = 0; n < 40; n++) begin
            logic [31:0] m;
            logic [7:0]  e;
            int          pos;
            pos = $urandom_range(0, 28);
            m = $urandom;
            if (pos == 28) m = 32'h0;
            else m = m & ((32'h1 << (pos + 1)) - 1);
            m = m | (32'($urandom_range(0, 15)) << 28);
            e = 8'($urandom);
            if (n % 4 == 0) e = 8'($urandom_range(0, 30));
            if (n % 7 == 0) e = 8'($urandom_range(250, 255));
            run_op(1'($urandom), e, m, $urandom_range(0, 3), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
